// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multicycle MIPS control sequencer with memory-ready stalls and retire counter
// Optional illegal-opcode trap state enabled by defining MC_SEQ_ILLEGAL_TRAP_EN.
module mc_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic             reg_write,
   output logic             reg_dst,
   output logic [1:0]       pc_source,
   output logic [1:0]       alu_op,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       state,
   output logic             instr_done,
   output logic [CNT_W-1:0] retired,
   output logic             illegal
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_TRAP   = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q;
   logic             pc_write, pc_write_cond;

   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      pc_source     = 2'b00;
      alu_op        = 2'b00;
      alu_src_b     = 2'b00;
      instr_done    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default: begin
`ifdef MC_SEQ_ILLEGAL_TRAP_EN
                  state_d = S_TRAP;
`else
                  // Unknown opcode retires as a NOP.
                  state_d    = S_FETCH;
                  instr_done = 1'b1;
`endif
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_RWB;
         end
         S_RWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            instr_done    = 1'b1;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
`ifdef MC_SEQ_ILLEGAL_TRAP_EN
         S_TRAP: state_d = S_TRAP;
`endif
         default: state_d = S_FETCH;
      endcase
      pc_en = pc_write | (pc_write_cond & zero);
      // Reset masks every control so a stalled access is dropped immediately.
      if (reset) begin
         pc_en      = 1'b0;
         iord       = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         mem_to_reg = 1'b0;
         alu_src_a  = 1'b0;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         pc_source  = 2'b00;
         alu_op     = 2'b00;
         alu_src_b  = 2'b00;
         instr_done = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (instr_done) retired_q <= retired_q + CNT_W'(1);
      end
   end

`ifdef MC_SEQ_ILLEGAL_TRAP_EN
   logic illegal_q;
   always_ff @(posedge clk) begin
      if (reset)                  illegal_q <= 1'b0;
      else if (state_d == S_TRAP) illegal_q <= 1'b1;
   end
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   assign state   = state_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - directed self-checking bench for mc_sequencer
// Exercises the MC_SEQ_ILLEGAL_TRAP_EN variant when that macro is defined.
module tb_mc_sequencer;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             reset, zero, mem_ready;
   logic [5:0]       opcode;
   logic             pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg;
   logic             alu_src_a, reg_write, reg_dst, instr_done, illegal;
   logic [1:0]       pc_source, alu_op, alu_src_b;
   logic [3:0]       state;
   logic [CNT_W-1:0] retired;

   int checks = 0;
   int errors = 0;

   mc_sequencer #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
      .ir_write(ir_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .reg_write(reg_write), .reg_dst(reg_dst), .pc_source(pc_source),
      .alu_op(alu_op), .alu_src_b(alu_src_b), .state(state),
      .instr_done(instr_done), .retired(retired), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // {pc_en,iord,mem_read,mem_write,ir_write,mem_to_reg,alu_src_a,reg_write,reg_dst,pc_source,alu_op,alu_src_b,instr_done}
   logic [15:0] ctl;
   assign ctl = {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, alu_src_a,
                 reg_write, reg_dst, pc_source, alu_op, alu_src_b, instr_done};

   localparam logic [15:0] C_FETCH    = 16'hA802;
   localparam logic [15:0] C_FETCH_ST = 16'h2002;
   localparam logic [15:0] C_DECODE   = 16'h0006;
   localparam logic [15:0] C_DEC_NOP  = 16'h0007;
   localparam logic [15:0] C_MEMADR   = 16'h0204;
   localparam logic [15:0] C_MEMRD    = 16'h6000;
   localparam logic [15:0] C_MEMWB    = 16'h0501;
   localparam logic [15:0] C_MEMWR_ST = 16'h5000;
   localparam logic [15:0] C_MEMWR    = 16'h5001;
   localparam logic [15:0] C_EXEC     = 16'h0210;
   localparam logic [15:0] C_RWB      = 16'h0181;
   localparam logic [15:0] C_BR_T     = 16'h8229;
   localparam logic [15:0] C_BR_NT    = 16'h0229;
   localparam logic [15:0] C_JUMP     = 16'h8041;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Check state/controls in the current cycle, then advance one clock.
   task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] c);
      #1;
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".ctl"}, 32'(ctl), 32'(c));
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.state", 32'(state), 0);
      chk("rst.ctl", 32'(ctl), 0);
      chk("rst.retired", 32'(retired), 0);
      chk("rst.illegal", 32'(illegal), 0);
      reset = 1'b0;

      opcode = 6'h23;
      cyc("lw.f", 4'd0, C_FETCH);
      cyc("lw.d", 4'd1, C_DECODE);
      cyc("lw.a", 4'd2, C_MEMADR);
      cyc("lw.r", 4'd3, C_MEMRD);
      chk("lw.ret_before", 32'(retired), 0);
      cyc("lw.wb", 4'd4, C_MEMWB);
      chk("lw.retired", 32'(retired), 1);

      opcode = 6'h2B;
      cyc("sw.f", 4'd0, C_FETCH);
      cyc("sw.d", 4'd1, C_DECODE);
      cyc("sw.a", 4'd2, C_MEMADR);
      mem_ready = 1'b0;
      cyc("sw.w0", 4'd5, C_MEMWR_ST);
      cyc("sw.w1", 4'd5, C_MEMWR_ST);
      mem_ready = 1'b1;
      cyc("sw.w2", 4'd5, C_MEMWR);
      chk("sw.retired", 32'(retired), 2);

      opcode = 6'h04; zero = 1'b1;
      cyc("beq1.f", 4'd0, C_FETCH);
      cyc("beq1.d", 4'd1, C_DECODE);
      cyc("beq1.b", 4'd8, C_BR_T);
      chk("beq1.retired", 32'(retired), 3);

      zero = 1'b0;
      cyc("beq0.f", 4'd0, C_FETCH);
      cyc("beq0.d", 4'd1, C_DECODE);
      #1;
      chk("beq0.zero_follow", 32'(pc_en), 0);
      zero = 1'b1;
      #1;
      chk("beq0.zero_comb", 32'(pc_en), 1);
      zero = 1'b0;
      cyc("beq0.b", 4'd8, C_BR_NT);
      chk("beq0.retired", 32'(retired), 4);

      mem_ready = 1'b0; opcode = 6'h00;
      cyc("fstall", 4'd0, C_FETCH_ST);
      mem_ready = 1'b1;
      cyc("r.f", 4'd0, C_FETCH);
      cyc("r.d", 4'd1, C_DECODE);
      cyc("r.e", 4'd6, C_EXEC);
      cyc("r.wb", 4'd7, C_RWB);
      opcode = 6'h02;
      cyc("j.f", 4'd0, C_FETCH);
      cyc("j.d", 4'd1, C_DECODE);
      cyc("j.j", 4'd9, C_JUMP);
      chk("rj.retired", 32'(retired), 6);

      opcode = 6'h3F;
      cyc("ill.f", 4'd0, C_FETCH);
`ifdef MC_SEQ_ILLEGAL_TRAP_EN
      cyc("ill.d", 4'd1, C_DECODE);
      for (int i = 0; i < 6; i++) begin
         chk("trap.illegal", 32'(illegal), 1);
         chk("trap.retired", 32'(retired), 6);
         cyc("trap", 4'd10, 16'h0000);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("trap.clr_illegal", 32'(illegal), 0);
      chk("trap.clr_state", 32'(state), 0);
`else
      cyc("nop.d", 4'd1, C_DEC_NOP);
      chk("nop.retired", 32'(retired), 7);
      chk("nop.illegal", 32'(illegal), 0);
      opcode = 6'h02;
      cyc("jw.f", 4'd0, C_FETCH);
      cyc("jw.d", 4'd1, C_DECODE);
      cyc("jw.j", 4'd9, C_JUMP);
      chk("wrap.retired", 32'(retired), 0);
`endif

      opcode = 6'h23;
      cyc("rs.f", 4'd0, C_FETCH);
      cyc("rs.d", 4'd1, C_DECODE);
      cyc("rs.a", 4'd2, C_MEMADR);
      mem_ready = 1'b0;
      cyc("rs.r", 4'd3, C_MEMRD);
      reset = 1'b1;
      #1;
      chk("rs.ctl_in_reset", 32'(ctl), 0);
      @(posedge clk);
      #1;
      chk("rs.state", 32'(state), 0);
      chk("rs.retired", 32'(retired), 0);
      chk("rs.ctl_held", 32'(ctl), 0);
      reset = 1'b0; mem_ready = 1'b1;
      cyc("rs.f2", 4'd0, C_FETCH);
      cyc("rs.d2", 4'd1, C_DECODE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
